// File: rtl/wb_stage_pkg.sv
// Shared types for the writeback stage: load-op encoding and the MEM->WB payload bus.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    LoadNone = 3'd0,
    LoadLw   = 3'd1,
    LoadLb   = 3'd2,
    LoadLbu  = 3'd3,
    LoadLh   = 3'd4,
    LoadLhu  = 3'd5,
    LoadLwl  = 3'd6,
    LoadLwr  = 3'd7
  } load_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        rf_we;
    logic [31:0] result;
    load_op_e    load_op;
    logic [31:0] load_data;
    logic [31:0] rt_old;
  } wb_bus_t;

  localparam int unsigned WbBusW = $bits(wb_bus_t);

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load data alignment and extension, including the LWL/LWR merge with old rt.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] rt_old_i,
  input  logic [31:0] result_i,
  output logic [31:0] data_o
);

  load_op_e    op;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    op       = load_op_e'(op_i);
    byte_sel = mem_data_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = mem_data_i[{addr_lo_i[1], 4'b0000} +: 16];
    data_o   = result_i;
    case (op)
      LoadLw:  data_o = mem_data_i;
      LoadLb:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LoadLbu: data_o = {24'h000000, byte_sel};
      LoadLh:  data_o = {{16{half_sel[15]}}, half_sel};
      LoadLhu: data_o = {16'h0000, half_sel};
      // LWL fills the high bytes from memory, LWR the low bytes; the rest keeps old rt.
      LoadLwl: begin
        case (addr_lo_i)
          2'd0:    data_o = {mem_data_i[7:0], rt_old_i[23:0]};
          2'd1:    data_o = {mem_data_i[15:0], rt_old_i[15:0]};
          2'd2:    data_o = {mem_data_i[23:0], rt_old_i[7:0]};
          default: data_o = mem_data_i;
        endcase
      end
      LoadLwr: begin
        case (addr_lo_i)
          2'd0:    data_o = mem_data_i;
          2'd1:    data_o = {rt_old_i[31:24], mem_data_i[31:8]};
          2'd2:    data_o = {rt_old_i[31:16], mem_data_i[31:16]};
          default: data_o = {rt_old_i[31:8], mem_data_i[31:24]};
        endcase
      end
      default: data_o = result_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: latches MEM results, aligns load data, drives regfile write, bypass and trace.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_to_wb_valid,
  output logic             wb_allowin,
  input  logic [31:0]      mem_pc,
  input  logic [4:0]       mem_dest,
  input  logic             mem_rf_we,
  input  logic [31:0]      mem_result,
  input  logic [2:0]       mem_load_op,
  input  logic [31:0]      mem_load_data,
  input  logic [31:0]      mem_rt_old,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             rf_w_enable,
  output logic [4:0]       rf_w_addr,
  output logic [31:0]      rf_w_data,
  output logic             fwd_valid,
  output logic [4:0]       fwd_dest,
  output logic [31:0]      fwd_data,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retired_count
);

  wb_bus_t          wb_q, wb_d, mem_bus;
  logic             wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic             ready_go, retire, writes_reg;
  logic [31:0]      wb_data;

  always_comb begin
    mem_bus = '{pc:        mem_pc,
                dest:      mem_dest,
                rf_we:     mem_rf_we,
                result:    mem_result,
                load_op:   load_op_e'(mem_load_op),
                load_data: mem_load_data,
                rt_old:    mem_rt_old};
  end

  // Raw load word is held and aligned here so the write lands one cycle after accept.
  wb_stage_load_align u_load_align (
    .op_i       (wb_q.load_op),
    .addr_lo_i  (wb_q.result[1:0]),
    .mem_data_i (wb_q.load_data),
    .rt_old_i   (wb_q.rt_old),
    .result_i   (wb_q.result),
    .data_o     (wb_data)
  );

  always_comb begin
    ready_go   = !wb_stall;
    wb_allowin = !wb_valid_q || ready_go;
    retire     = wb_valid_q && ready_go && !wb_flush;
    writes_reg = wb_q.rf_we && (wb_q.dest != 5'd0);

    wb_d = wb_q;
    if (mem_to_wb_valid && wb_allowin) begin
      wb_d = mem_bus;
    end

    // Flush wins over a simultaneous accept.
    if (wb_flush) begin
      wb_valid_d = 1'b0;
    end else if (wb_allowin) begin
      wb_valid_d = mem_to_wb_valid;
    end else begin
      wb_valid_d = wb_valid_q;
    end

    retired_count_d = retired_count_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q            <= '0;
      wb_valid_q      <= 1'b0;
      retired_count_q <= '0;
    end else begin
      wb_q            <= wb_d;
      wb_valid_q      <= wb_valid_d;
      retired_count_q <= retired_count_d;
    end
  end

  always_comb begin
    rf_w_enable       = retire && writes_reg;
    rf_w_addr         = wb_q.dest;
    rf_w_data         = wb_data;
    fwd_valid         = wb_valid_q && writes_reg;
    fwd_dest          = wb_q.dest;
    fwd_data          = wb_data;
    debug_wb_pc       = wb_q.pc;
    debug_wb_rf_wen   = {4{rf_w_enable}};
    debug_wb_rf_wnum  = wb_q.dest;
    debug_wb_rf_wdata = wb_data;
    retired_count     = retired_count_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a model.
module tb_wb_stage;

  localparam logic [2:0] OP_NONE = 3'd0, OP_LW = 3'd1, OP_LB = 3'd2, OP_LBU = 3'd3;
  localparam logic [2:0] OP_LH = 3'd4, OP_LHU = 3'd5, OP_LWL = 3'd6, OP_LWR = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_to_wb_valid, wb_allowin;
  logic [31:0] mem_pc, mem_result, mem_load_data, mem_rt_old;
  logic [4:0]  mem_dest;
  logic        mem_rf_we;
  logic [2:0]  mem_load_op;
  logic        wb_stall, wb_flush;
  logic        rf_w_enable, fwd_valid;
  logic [4:0]  rf_w_addr, fwd_dest, debug_wb_rf_wnum;
  logic [31:0] rf_w_data, fwd_data, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .wb_allowin        (wb_allowin),
    .mem_pc            (mem_pc),
    .mem_dest          (mem_dest),
    .mem_rf_we         (mem_rf_we),
    .mem_result        (mem_result),
    .mem_load_op       (mem_load_op),
    .mem_load_data     (mem_load_data),
    .mem_rt_old        (mem_rt_old),
    .wb_stall          (wb_stall),
    .wb_flush          (wb_flush),
    .rf_w_enable       (rf_w_enable),
    .rf_w_addr         (rf_w_addr),
    .rf_w_data         (rf_w_data),
    .fwd_valid         (fwd_valid),
    .fwd_dest          (fwd_dest),
    .fwd_data          (fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retired_count     (retired_count)
  );

  // Reference alignment using shifts and masks on whole words.
  function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [31:0] res,
                                            input logic [31:0] m, input logic [31:0] r);
    int          a;
    int          sh;
    logic [31:0] v;
    a = int'(res[1:0]);
    case (op)
      OP_LW: v = m;
      OP_LB, OP_LBU: begin
        v = (m >> (8 * a)) & 32'hFF;
        if (op == OP_LB && v[7]) v = v | 32'hFFFF_FF00;
      end
      OP_LH, OP_LHU: begin
        v = (m >> (16 * (a / 2))) & 32'hFFFF;
        if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
      end
      OP_LWL: begin
        sh = 8 * (3 - a);
        v  = (m << sh) | (r & ((32'd1 << sh) - 32'd1));
      end
      OP_LWR: begin
        sh = 8 * a;
        v  = (m >> sh) | (r & ~(32'hFFFF_FFFF >> sh));
      end
      default: v = res;
    endcase
    return v;
  endfunction

  task automatic drive_idle();
    mem_to_wb_valid = 1'b0;
    mem_pc = '0; mem_dest = '0; mem_rf_we = 1'b0; mem_result = '0;
    mem_load_op = OP_NONE; mem_load_data = '0; mem_rt_old = '0;
    wb_stall = 1'b0; wb_flush = 1'b0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] dest, input logic we,
                             input logic [31:0] res, input logic [2:0] op,
                             input logic [31:0] m, input logic [31:0] r);
    mem_to_wb_valid = 1'b1;
    mem_pc = pc; mem_dest = dest; mem_rf_we = we; mem_result = res;
    mem_load_op = op; mem_load_data = m; mem_rt_old = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rf_w_enable, rf_w_addr, rf_w_data, fwd_valid, fwd_dest, fwd_data, debug_wb_pc,
         debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, retired_count} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs (count=%0d wen=%b) want all zero",
               retired_count, rf_w_enable);
    else n_pass++;
    n_checks++;
    if (wb_allowin !== 1'b1) $display("FAIL reset_allowin: got %b want 1", wb_allowin);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive_instr(32'hBFC0_0000, 5'd3, 1'b1, 32'h1234_5678, OP_NONE, 32'h0, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if ({rf_w_enable, rf_w_addr, rf_w_data} !== {1'b1, 5'd3, 32'h1234_5678})
      $display("FAIL add_write: got en=%b addr=%0d data=%h want en=1 addr=3 data=12345678",
               rf_w_enable, rf_w_addr, rf_w_data);
    else n_pass++;
    n_checks++;
    if ({debug_wb_pc, debug_wb_rf_wen} !== {32'hBFC0_0000, 4'hF})
      $display("FAIL add_trace: got pc=%h wen=%h want pc=bfc00000 wen=f",
               debug_wb_pc, debug_wb_rf_wen);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rf_w_enable, retired_count} !== {1'b0, 32'd1})
      $display("FAIL add_count: got en=%b count=%0d want en=0 count=1", rf_w_enable,
               retired_count);
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [2:0]  ops [5] = '{OP_LB, OP_LBU, OP_LH, OP_LWL, OP_LWR};
    logic [31:0] res [5] = '{32'h1000_0002, 32'h1000_0002, 32'h1000_0002, 32'h1000_0001,
                            32'h1000_0001};
    logic [31:0] mem [5] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'hAABB_CCDD,
                            32'hAABB_CCDD};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hCCDD_3344,
                            32'h11AA_BBCC};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_instr(32'h100 + 4 * i, 5'd8, 1'b1, res[i], ops[i], mem[i], 32'h1122_3344);
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++;
      if (rf_w_enable !== 1'b1 || rf_w_data !== exp[i] || fwd_data !== exp[i])
        $display("FAIL load_align[%0d]: got en=%b data=%h fwd=%h want en=1 data=%h", i,
                 rf_w_enable, rf_w_data, fwd_data, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_dest_zero();
    logic [31:0] c0;
    @(negedge clk);
    c0 = retired_count;
    drive_instr(32'h200, 5'd0, 1'b1, 32'hDEAD_BEEF, OP_NONE, 32'h0, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if ({rf_w_enable, fwd_valid, debug_wb_rf_wen} !== 6'b0)
      $display("FAIL dest_zero_write: got en=%b fwd=%b wen=%h want all 0", rf_w_enable,
               fwd_valid, debug_wb_rf_wen);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (retired_count !== c0 + 32'd1)
      $display("FAIL dest_zero_count: got %0d want %0d", retired_count, c0 + 32'd1);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    int          writes;
    int          bad;
    @(negedge clk);
    c0 = retired_count;
    writes = 0;
    bad = 0;
    drive_instr(32'h300, 5'd5, 1'b1, 32'hA5A5_0001, OP_NONE, 32'h0, 32'h0);
    @(negedge clk);
    drive_instr(32'h304, 5'd6, 1'b1, 32'hA5A5_0002, OP_NONE, 32'h0, 32'h0);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (wb_allowin !== 1'b0 || rf_w_enable !== 1'b0 || fwd_valid !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) $display("FAIL stall_hold: got %0d bad stalled cycles want 0", bad);
    else n_pass++;
    wb_stall = 1'b0;
    #1;
    n_checks++;
    if ({rf_w_enable, rf_w_addr, rf_w_data} !== {1'b1, 5'd5, 32'hA5A5_0001})
      $display("FAIL stall_release: got en=%b addr=%0d data=%h want en=1 addr=5 data=a5a50001",
               rf_w_enable, rf_w_addr, rf_w_data);
    else n_pass++;
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if ({rf_w_enable, rf_w_addr, rf_w_data} !== {1'b1, 5'd6, 32'hA5A5_0002})
      $display("FAIL stall_next: got en=%b addr=%0d data=%h want en=1 addr=6 data=a5a50002",
               rf_w_enable, rf_w_addr, rf_w_data);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      if (rf_w_enable) writes++;
    end
    n_checks++;
    if (writes != 0 || retired_count !== c0 + 32'd2)
      $display("FAIL stall_count: got extra_writes=%0d count=%0d want 0 and %0d", writes,
               retired_count, c0 + 32'd2);
    else n_pass++;
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] c0;
    @(negedge clk);
    c0 = retired_count;
    drive_instr(32'h400, 5'd7, 1'b1, 32'h0000_0777, OP_NONE, 32'h0, 32'h0);
    @(negedge clk);
    drive_instr(32'h404, 5'd9, 1'b1, 32'h0000_0999, OP_NONE, 32'h0, 32'h0);
    wb_flush = 1'b1;
    #1;
    n_checks++;
    if ({rf_w_enable, debug_wb_rf_wen} !== 5'b0)
      $display("FAIL flush_kill: got en=%b wen=%h want 0", rf_w_enable, debug_wb_rf_wen);
    else n_pass++;
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if ({rf_w_enable, fwd_valid, wb_allowin} !== 3'b001 || retired_count !== c0)
      $display("FAIL flush_after: got en=%b fwd=%b allow=%b count=%0d want 0 0 1 count=%0d",
               rf_w_enable, fwd_valid, wb_allowin, retired_count, c0);
    else n_pass++;
    drive_instr(32'h500, 5'd10, 1'b1, 32'h0000_0AAA, OP_NONE, 32'h0, 32'h0);
    @(negedge clk);
    drive_idle();
    wb_stall = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wb_stall = 1'b0;
    #1;
    n_checks++;
    if ({rf_w_enable, rf_w_addr, rf_w_data, fwd_valid, fwd_dest, fwd_data, debug_wb_pc,
         debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, retired_count} !== '0)
      $display("FAIL reset_mid_stall: got en=%b pc=%h count=%0d want all zero", rf_w_enable,
               debug_wb_pc, retired_count);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        m_valid, m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_pc, m_data, m_count;
    logic        retire_e, wen_e, fwd_e, allow_e;
    int          bad_ctl, bad_data, bad_cnt;
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0; m_we = 1'b0; m_dest = '0; m_pc = '0; m_data = '0; m_count = '0;
    bad_ctl = 0; bad_data = 0; bad_cnt = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      mem_to_wb_valid = ($urandom_range(0, 9) < 7);
      mem_pc        = $urandom & 32'hFFFF_FFFC;
      mem_dest      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      mem_rf_we     = ($urandom_range(0, 5) != 0);
      mem_result    = $urandom;
      mem_load_op   = 3'($urandom);
      mem_load_data = $urandom;
      mem_rt_old    = $urandom;
      wb_stall      = ($urandom_range(0, 3) == 0);
      wb_flush      = ($urandom_range(0, 11) == 0);
      #1;
      retire_e = m_valid && !wb_stall && !wb_flush;
      wen_e    = retire_e && m_we && (m_dest != 5'd0);
      fwd_e    = m_valid && m_we && (m_dest != 5'd0);
      allow_e  = !m_valid || !wb_stall;
      if (rf_w_enable !== wen_e || fwd_valid !== fwd_e || wb_allowin !== allow_e ||
          debug_wb_rf_wen !== {4{wen_e}}) begin
        bad_ctl++;
        if (bad_ctl <= 4)
          $display("FAIL rand_ctl cyc %0d: got en=%b fwd=%b allow=%b want %b %b %b", cyc,
                   rf_w_enable, fwd_valid, wb_allowin, wen_e, fwd_e, allow_e);
      end
      if (fwd_e && (fwd_data !== m_data || fwd_dest !== m_dest ||
                    (wen_e && (rf_w_data !== m_data || rf_w_addr !== m_dest ||
                               debug_wb_pc !== m_pc || debug_wb_rf_wdata !== m_data)))) begin
        bad_data++;
        if (bad_data <= 4)
          $display("FAIL rand_data cyc %0d: got dest=%0d data=%h want dest=%0d data=%h", cyc,
                   fwd_dest, fwd_data, m_dest, m_data);
      end
      if (retired_count !== m_count) begin
        bad_cnt++;
        if (bad_cnt <= 4)
          $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, retired_count, m_count);
      end
      m_count = m_count + 32'(retire_e);
      if (wb_flush) begin
        m_valid = 1'b0;
      end else if (allow_e) begin
        m_valid = mem_to_wb_valid;
        m_pc    = mem_pc;
        m_dest  = mem_dest;
        m_we    = mem_rf_we;
        m_data  = ref_align(mem_load_op, mem_result, mem_load_data, mem_rt_old);
      end
      @(negedge clk);
    end
    n_checks++;
    if (bad_ctl != 0) $display("FAIL rand_ctl_total: got %0d bad cycles want 0", bad_ctl);
    else n_pass++;
    n_checks++;
    if (bad_data != 0) $display("FAIL rand_data_total: got %0d bad cycles want 0", bad_data);
    else n_pass++;
    n_checks++;
    if (bad_cnt != 0) $display("FAIL rand_count_total: got %0d bad cycles want 0", bad_cnt);
    else n_pass++;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_add();
    test_loads();
    test_dest_zero();
    test_stall();
    test_flush_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
